init_cmd_sequencer: RTL and testbench
=====================================

// Module: init_cmd_sequencer
// PURPOSE
//  Control-word sequencer for the 8259A PIC: consumes decoded CPU writes from the bus
//  control logic and walks the ICW1->ICW2->[ICW3]->[ICW4] initialisation sequence.
//  Afterwards, it routes OCW1/OCW2/OCW3 writes.
//  Holds all programmed configuration registers and issues one-cycle command pulses.
//  These pulses drive the priority resolver, IMR/ISR logic and cascade logic.
// PARAMETERS
//  SLAVE_ID_RST  3'd7  slave_id value loaded on reset and on every ICW1
// PORTS
//  clk            in   1  system clock; all state changes on rising edge
//  reset          in   1  synchronous, active-high; wins over any same-cycle write
//  wr_strobe      in   1  one-cycle pulse per CPU write (CS_bar & WR_bar low, edge-detected upstream)
//  A0             in   1  address bit sampled with wr_strobe
//  data_in        in   8  write data sampled with wr_strobe
//  init_done      out  1  1 = READY state (initialisation complete)
//  ltim           out  1  ICW1.D3: 1 = level-triggered, 0 = edge
//  single         out  1  ICW1.D1: 1 = single PIC (ICW3 skipped)
//  vector_base    out  5  ICW2.D7..D3 (x86 vector T7..T3)
//  cascade_cfg    out  8  ICW3 raw byte (master: slave mask; slave: D2..D0 = id)
//  aeoi           out  1  ICW4.D1 auto-EOI
//  sfnm           out  1  ICW4.D4 special fully nested mode
//  imr            out  8  OCW1 interrupt mask register
//  special_mask   out  1  OCW3 special-mask mode
//  read_isr       out  1  OCW3 read select: 1 = ISR, 0 = IRR
//  icw1_pulse     out  1  1-cycle: ICW1 accepted (priority/ISR logic clears)
//  ocw2_pulse     out  1  1-cycle: OCW2 accepted; fields on ocw2_rsl/ocw2_lvl
//  ocw2_rsl       out  3  OCW2.D7..D5 (R, SL, EOI), registered with ocw2_pulse
//  ocw2_lvl       out  3  OCW2.D2..D0 level, registered with ocw2_pulse
//  poll_pulse     out  1  1-cycle: OCW3 with P (D2) = 1
// BEHAVIOUR
//  States: UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
//  Only cycles with wr_strobe=1 are decoded. Outputs are registered; pulses appear the cycle after wr_strobe.
//  ICW1 (A0=0, D4=1) from ANY state:
//   - ltim<=D3, single<=D1, ic4<=D0 (internal); go WAIT_ICW2.
//   - Clear imr, special_mask, read_isr, aeoi, sfnm and cascade_cfg.
//   - Load slave id: cascade_cfg[2:0]<=SLAVE_ID_RST.
//   - Pulse icw1_pulse; init_done<=0.
//  WAIT_ICW2, A0=1: vector_base<=D7..D3.
//   - Next state: single=0 -> WAIT_ICW3; else ic4=1 -> WAIT_ICW4; else READY.
//  WAIT_ICW3, A0=1: cascade_cfg<=data_in; next WAIT_ICW4 if ic4, else READY.
//  WAIT_ICW4, A0=1: aeoi<=D1, sfnm<=D4 (other bits ignored); -> READY.
//  Ignored writes (no state or register change):
//   - In WAIT_* states, A0=0 writes other than ICW1.
//   - In UNINIT, any write other than ICW1.
//  READY:
//   - A0=1: imr<=data_in (OCW1).
//   - A0=0, D4=0, D3=0: OCW2; latch ocw2_rsl/ocw2_lvl and pulse ocw2_pulse.
//   - A0=0, D4=0, D3=1: OCW3.
//     - If D6 (ESMM)=1: special_mask<=D5.
//     - If D1 (RR)=1: read_isr<=D0.
//     - If D2=1: pulse poll_pulse.
//  init_done=1 exactly in READY. Each state advances on one accepted write only.
//  Reset values: state=UNINIT; all outputs 0 except cascade_cfg=={5'b0,SLAVE_ID_RST}; pulses 0.
//  ocw2_rsl/ocw2_lvl hold their last value between pulses.
//  Reset in the same cycle as wr_strobe: the write is discarded.
//  A new ICW1 in the middle of the sequence restarts cleanly; prior ICW2..4 values are not retained.
// TESTING
//  1 ICW1=0x13 (single, IC4), ICW2=0x20, ICW4=0x03 -> vector_base=5'h04, aeoi=1, init_done=1 after 3rd write; cascade_cfg=0x07.
//  2 ICW1=0x11 (cascade), ICW2=0x08, ICW3=0x04, ICW4=0x01 -> cascade_cfg=0x04, aeoi=0; no READY before 4th write.
//  3 In READY: A0=1 0xFB -> imr=0xFB. A0=0 0x20 -> ocw2_pulse 1 cycle, ocw2_rsl=3'b001, ocw2_lvl=0. A0=0 0x0B -> read_isr=1. A0=0 0x0C -> poll_pulse.
//  4 A0=0 0x68 -> special_mask=1; then 0x48 -> special_mask=0; 0x28 (ESMM=0) -> special_mask unchanged.
//  5 ICW1=0x11, ICW2, then ICW1=0x13 mid-sequence -> icw1_pulse twice, imr cleared, state WAIT_ICW2; A0=0 0x20 in WAIT_ICW2 ignored.
//  6 reset asserted with wr_strobe carrying ICW1 -> state UNINIT, icw1_pulse stays 0; A0=1 write in UNINIT leaves imr=0.

Source files
------------

// File: rtl/init_cmd_sequencer_if.sv
// CPU write bus between the bus control logic and the 8259A control-word sequencer.
// The bus control logic drives it; the sequencer samples it.
interface init_cmd_sequencer_if;
  logic       wr_strobe;
  logic       A0;
  logic [7:0] data_in;

  modport master (output wr_strobe, A0, data_in);
  modport slave  (input  wr_strobe, A0, data_in);
endinterface

// File: rtl/init_cmd_sequencer.sv
// 8259A control-word sequencer.
// Walks the ICW1..ICW4 initialisation sequence and then routes OCW1/OCW2/OCW3 writes.
// Holds the programmed configuration and issues one-cycle command pulses.
module init_cmd_sequencer #(
  parameter logic [2:0] SLAVE_ID_RST = 3'd7
) (
  input  logic                        clk,
  input  logic                        reset,
  init_cmd_sequencer_if.slave         bus,
  output logic                        init_done,
  output logic                        ltim,
  output logic                        single,
  output logic [4:0]                  vector_base,
  output logic [7:0]                  cascade_cfg,
  output logic                        aeoi,
  output logic                        sfnm,
  output logic [7:0]                  imr,
  output logic                        special_mask,
  output logic                        read_isr,
  output logic                        icw1_pulse,
  output logic                        ocw2_pulse,
  output logic [2:0]                  ocw2_rsl,
  output logic [2:0]                  ocw2_lvl,
  output logic                        poll_pulse
);

  localparam logic [2:0] UNINIT    = 3'd0;
  localparam logic [2:0] WAIT_ICW2 = 3'd1;
  localparam logic [2:0] WAIT_ICW3 = 3'd2;
  localparam logic [2:0] WAIT_ICW4 = 3'd3;
  localparam logic [2:0] READY     = 3'd4;

  logic [2:0] state_q, state_d;
  logic       ltim_q, ltim_d;
  logic       single_q, single_d;
  logic       ic4_q, ic4_d;
  logic [4:0] vector_base_q, vector_base_d;
  logic [7:0] cascade_cfg_q, cascade_cfg_d;
  logic       aeoi_q, aeoi_d;
  logic       sfnm_q, sfnm_d;
  logic [7:0] imr_q, imr_d;
  logic       special_mask_q, special_mask_d;
  logic       read_isr_q, read_isr_d;
  logic       icw1_pulse_q, icw1_pulse_d;
  logic       ocw2_pulse_q, ocw2_pulse_d;
  logic [2:0] ocw2_rsl_q, ocw2_rsl_d;
  logic [2:0] ocw2_lvl_q, ocw2_lvl_d;
  logic       poll_pulse_q, poll_pulse_d;

  logic [7:0] d;
  logic       is_icw1;

  assign d       = bus.data_in;
  assign is_icw1 = bus.wr_strobe && !bus.A0 && d[4];

  // Decode one accepted write into next state, config registers and command pulses
  always_comb begin
    state_d        = state_q;
    ltim_d         = ltim_q;
    single_d       = single_q;
    ic4_d          = ic4_q;
    vector_base_d  = vector_base_q;
    cascade_cfg_d  = cascade_cfg_q;
    aeoi_d         = aeoi_q;
    sfnm_d         = sfnm_q;
    imr_d          = imr_q;
    special_mask_d = special_mask_q;
    read_isr_d     = read_isr_q;
    ocw2_rsl_d     = ocw2_rsl_q;
    ocw2_lvl_d     = ocw2_lvl_q;
    icw1_pulse_d   = 1'b0;
    ocw2_pulse_d   = 1'b0;
    poll_pulse_d   = 1'b0;

    if (is_icw1) begin
      ltim_d         = d[3];
      single_d       = d[1];
      ic4_d          = d[0];
      imr_d          = 8'h00;
      special_mask_d = 1'b0;
      read_isr_d     = 1'b0;
      aeoi_d         = 1'b0;
      sfnm_d         = 1'b0;
      cascade_cfg_d  = {5'b0, SLAVE_ID_RST};
      icw1_pulse_d   = 1'b1;
      state_d        = WAIT_ICW2;
    end else if (bus.wr_strobe) begin
      case (state_q)
        WAIT_ICW2: if (bus.A0) begin
          vector_base_d = d[7:3];
          if (!single_q)  state_d = WAIT_ICW3;
          else if (ic4_q) state_d = WAIT_ICW4;
          else            state_d = READY;
        end
        WAIT_ICW3: if (bus.A0) begin
          cascade_cfg_d = d;
          state_d       = ic4_q ? WAIT_ICW4 : READY;
        end
        WAIT_ICW4: if (bus.A0) begin
          aeoi_d  = d[1];
          sfnm_d  = d[4];
          state_d = READY;
        end
        READY: begin
          if (bus.A0) begin
            imr_d = d;
          end else if (!d[3]) begin
            ocw2_rsl_d   = d[7:5];
            ocw2_lvl_d   = d[2:0];
            ocw2_pulse_d = 1'b1;
          end else begin
            if (d[6]) special_mask_d = d[5];
            if (d[1]) read_isr_d     = d[0];
            poll_pulse_d = d[2];
          end
        end
        default: ;
      endcase
    end
  end

  // Register all state; reset overrides any write in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= UNINIT;
      ltim_q         <= 1'b0;
      single_q       <= 1'b0;
      ic4_q          <= 1'b0;
      vector_base_q  <= 5'd0;
      cascade_cfg_q  <= {5'b0, SLAVE_ID_RST};
      aeoi_q         <= 1'b0;
      sfnm_q         <= 1'b0;
      imr_q          <= 8'h00;
      special_mask_q <= 1'b0;
      read_isr_q     <= 1'b0;
      icw1_pulse_q   <= 1'b0;
      ocw2_pulse_q   <= 1'b0;
      ocw2_rsl_q     <= 3'd0;
      ocw2_lvl_q     <= 3'd0;
      poll_pulse_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      ltim_q         <= ltim_d;
      single_q       <= single_d;
      ic4_q          <= ic4_d;
      vector_base_q  <= vector_base_d;
      cascade_cfg_q  <= cascade_cfg_d;
      aeoi_q         <= aeoi_d;
      sfnm_q         <= sfnm_d;
      imr_q          <= imr_d;
      special_mask_q <= special_mask_d;
      read_isr_q     <= read_isr_d;
      icw1_pulse_q   <= icw1_pulse_d;
      ocw2_pulse_q   <= ocw2_pulse_d;
      ocw2_rsl_q     <= ocw2_rsl_d;
      ocw2_lvl_q     <= ocw2_lvl_d;
      poll_pulse_q   <= poll_pulse_d;
    end
  end

  assign init_done    = (state_q == READY);
  assign ltim         = ltim_q;
  assign single       = single_q;
  assign vector_base  = vector_base_q;
  assign cascade_cfg  = cascade_cfg_q;
  assign aeoi         = aeoi_q;
  assign sfnm         = sfnm_q;
  assign imr          = imr_q;
  assign special_mask = special_mask_q;
  assign read_isr     = read_isr_q;
  assign icw1_pulse   = icw1_pulse_q;
  assign ocw2_pulse   = ocw2_pulse_q;
  assign ocw2_rsl     = ocw2_rsl_q;
  assign ocw2_lvl     = ocw2_lvl_q;
  assign poll_pulse   = poll_pulse_q;

endmodule

// File: tb/tb_init_cmd_sequencer.sv
// Directed testbench for the 8259A control-word sequencer.
module tb_init_cmd_sequencer;
  logic       clk;
  logic       reset;
  logic       init_done, ltim, single, aeoi, sfnm, special_mask, read_isr;
  logic       icw1_pulse, ocw2_pulse, poll_pulse;
  logic [4:0] vector_base;
  logic [7:0] cascade_cfg, imr;
  logic [2:0] ocw2_rsl, ocw2_lvl;

  int checks = 0;
  int errors = 0;

  init_cmd_sequencer_if bus ();

  init_cmd_sequencer #(.SLAVE_ID_RST(3'd7)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .init_done(init_done), .ltim(ltim), .single(single),
    .vector_base(vector_base), .cascade_cfg(cascade_cfg),
    .aeoi(aeoi), .sfnm(sfnm), .imr(imr),
    .special_mask(special_mask), .read_isr(read_isr),
    .icw1_pulse(icw1_pulse), .ocw2_pulse(ocw2_pulse),
    .ocw2_rsl(ocw2_rsl), .ocw2_lvl(ocw2_lvl), .poll_pulse(poll_pulse)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One compare point: counts the check and reports any difference
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one write for exactly one clock, leaving outputs ready to sample at the next negedge
  task automatic apply_stimulus(input logic a0, input logic [7:0] data);
    @(negedge clk);
    bus.wr_strobe = 1'b1;
    bus.A0        = a0;
    bus.data_in   = data;
    @(negedge clk);
    bus.wr_strobe = 1'b0;
    bus.A0        = 1'b0;
    bus.data_in   = 8'h00;
  endtask

  // Directed sequence of writes with hand-computed expectations
  initial begin
    reset         = 1'b1;
    bus.wr_strobe = 1'b0;
    bus.A0        = 1'b0;
    bus.data_in   = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_init_done", init_done, 0);
    check("rst_cascade",   cascade_cfg, 8'h07);
    check("rst_imr",       imr, 0);
    check("rst_pulses",    {icw1_pulse, ocw2_pulse, poll_pulse}, 0);
    check("rst_vector",    vector_base, 0);

    // Single PIC with ICW4
    apply_stimulus(1'b0, 8'h13);
    check("t1_icw1_pulse", icw1_pulse, 1);
    check("t1_single",     single, 1);
    check("t1_ltim",       ltim, 0);
    check("t1_cascade",    cascade_cfg, 8'h07);
    @(negedge clk);
    check("t1_icw1_pulse_drop", icw1_pulse, 0);
    apply_stimulus(1'b1, 8'h20);
    check("t1_vector",     vector_base, 5'h04);
    check("t1_not_ready2", init_done, 0);
    apply_stimulus(1'b1, 8'h03);
    check("t1_aeoi",       aeoi, 1);
    check("t1_sfnm",       sfnm, 0);
    check("t1_ready",      init_done, 1);

    // Cascade mode: ICW3 included
    apply_stimulus(1'b0, 8'h11);
    check("t2_aeoi_clr",   aeoi, 0);
    check("t2_single",     single, 0);
    check("t2_not_ready1", init_done, 0);
    apply_stimulus(1'b1, 8'h08);
    check("t2_vector",     vector_base, 5'h01);
    check("t2_not_ready2", init_done, 0);
    apply_stimulus(1'b1, 8'h04);
    check("t2_cascade",    cascade_cfg, 8'h04);
    check("t2_not_ready3", init_done, 0);
    apply_stimulus(1'b1, 8'h01);
    check("t2_aeoi",       aeoi, 0);
    check("t2_ready",      init_done, 1);

    // Operation commands in READY
    apply_stimulus(1'b1, 8'hFB);
    check("t3_imr",        imr, 8'hFB);
    apply_stimulus(1'b0, 8'h20);
    check("t3_ocw2_pulse", ocw2_pulse, 1);
    check("t3_ocw2_rsl",   ocw2_rsl, 3'b001);
    check("t3_ocw2_lvl",   ocw2_lvl, 3'd0);
    @(negedge clk);
    check("t3_ocw2_drop",  ocw2_pulse, 0);
    apply_stimulus(1'b0, 8'h0B);
    check("t3_read_isr",   read_isr, 1);
    check("t3_no_poll",    poll_pulse, 0);
    apply_stimulus(1'b0, 8'h0C);
    check("t3_poll",       poll_pulse, 1);
    check("t3_read_isr_hold", read_isr, 1);
    @(negedge clk);
    check("t3_poll_drop",  poll_pulse, 0);
    check("t3_rsl_hold",   ocw2_rsl, 3'b001);
    apply_stimulus(1'b0, 8'h63);
    check("t3_rsl2",       ocw2_rsl, 3'b011);
    check("t3_lvl2",       ocw2_lvl, 3'd3);

    // Special mask mode
    apply_stimulus(1'b0, 8'h68);
    check("t4_smm_set",    special_mask, 1);
    apply_stimulus(1'b0, 8'h48);
    check("t4_smm_clr",    special_mask, 0);
    apply_stimulus(1'b0, 8'h68);
    apply_stimulus(1'b0, 8'h28);
    check("t4_smm_hold",   special_mask, 1);
    check("t4_imr_hold",   imr, 8'hFB);

    // Restart in mid-sequence
    apply_stimulus(1'b0, 8'h11);
    check("t5_icw1_a",     icw1_pulse, 1);
    check("t5_imr_clr",    imr, 0);
    check("t5_smm_clr",    special_mask, 0);
    check("t5_risr_clr",   read_isr, 0);
    check("t5_cascade",    cascade_cfg, 8'h07);
    apply_stimulus(1'b1, 8'h08);
    apply_stimulus(1'b0, 8'h13);
    check("t5_icw1_b",     icw1_pulse, 1);
    check("t5_not_ready",  init_done, 0);
    apply_stimulus(1'b0, 8'h20);
    check("t5_ign_ocw2",   ocw2_pulse, 0);
    check("t5_ign_icw1",   icw1_pulse, 0);
    apply_stimulus(1'b1, 8'h40);
    check("t5_vector",     vector_base, 5'h08);
    check("t5_skip_icw3",  init_done, 0);
    apply_stimulus(1'b1, 8'h12);
    check("t5_aeoi",       aeoi, 1);
    check("t5_sfnm",       sfnm, 1);
    check("t5_ready",      init_done, 1);

    // Reset colliding with an ICW1 write
    @(negedge clk);
    reset         = 1'b1;
    bus.wr_strobe = 1'b1;
    bus.A0        = 1'b0;
    bus.data_in   = 8'h13;
    @(negedge clk);
    bus.wr_strobe = 1'b0;
    bus.data_in   = 8'h00;
    reset         = 1'b0;
    check("t6_icw1_blocked", icw1_pulse, 0);
    check("t6_uninit",       init_done, 0);
    check("t6_aeoi_rst",     aeoi, 0);
    apply_stimulus(1'b1, 8'hAA);
    check("t6_imr_ign",      imr, 0);
    apply_stimulus(1'b0, 8'h20);
    check("t6_ocw2_ign",     ocw2_pulse, 0);
    apply_stimulus(1'b1, 8'h40);
    check("t6_vector_ign",   vector_base, 0);
    apply_stimulus(1'b0, 8'h12);
    apply_stimulus(1'b1, 8'hF8);
    check("t6_ready_noicw4", init_done, 1);
    check("t6_vector",       vector_base, 5'h1F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
